inst_fetch_axi: RTL and testbench

Instruction-fetch responder that services the program counter's fetch request (`pc`, `ce`) by issuing AXI4-Lite read transactions and returning the fetched instruction word to the IF/ID stage. It sits between the PC register and the instruction-side AXI-Lite master port of the core. It raises a stall request while a fetch is outstanding, so the PC holds its value. It also absorbs pipeline flushes without violating AXI handshake rules.

---
 rtl/inst_fetch_axi.sv | 197 +++++++++++++++++++
 tb/tb_inst_fetch_axi.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_axi.sv
// ---------------------------------------------------------------------------
// inst_fetch_axi
// Instruction-fetch responder between the PC register and the instruction-side
// AXI4-Lite read master port. Each fetch request from the PC becomes exactly
// one AR/R transaction. The fetched word is presented to IF/ID. A stall is
// requested while a fetch is outstanding. Flushes are absorbed without ever
// withdrawing a started AXI handshake.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   pc_i, ce_i          fetch address / fetch enable from the PC
//   stall_i             IF/ID has not yet consumed the delivered instruction
//   flush               discard in-flight or delivered instruction
//   inst_o              fetched instruction, 0 (NOP) whenever not valid
//   stallreq_o          combinational stall request to the pipeline control
//   bus_err_o           one-cycle pulse on RRESP error or misaligned PC
//   m_ar*, m_r*         AXI4-Lite read address / read data channels
// ---------------------------------------------------------------------------
module inst_fetch_axi #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              stall_i,
    input  logic              flush,
    output logic [DATA_W-1:0] inst_o,
    output logic              stallreq_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_flushed;
    logic [DATA_W-1:0]   r_inst;
    logic                r_bus_err;
    logic [ADDR_W-1:0]   r_araddr;
    logic                r_arvalid;
    logic                r_rready;
    logic                w_aligned;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_drop;

    assign w_aligned = (pc_i[1:0] == 2'b00);
    assign w_ar_hs   = r_arvalid & m_arready;
    assign w_r_hs    = r_rready & m_rvalid;
    // Data is dead if it was flushed earlier or a flush arrives with it.
    assign w_drop    = r_flushed | flush;

    assign inst_o    = r_inst;
    assign bus_err_o = r_bus_err;
    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;
    assign m_arprot  = 3'b100;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (ce_i && !flush) begin
                    w_state_nxt = w_aligned ? S_ADDR : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADDR: begin
                if (w_ar_hs) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_DATA: begin
                if (w_r_hs) begin
                    w_state_nxt = w_drop ? S_IDLE : S_DONE;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DONE: begin
                if (flush || !stall_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output comb: stall while a fetch is being started or is outstanding.
    always_comb begin
        stallreq_o = 1'b0;
        if (r_state == S_IDLE) begin
            stallreq_o = ce_i & ~flush;
        end else if ((r_state == S_ADDR) || (r_state == S_DATA)) begin
            stallreq_o = 1'b1;
        end else begin
            stallreq_o = 1'b0;
        end
    end

    // Registered AXI controls, instruction word, error pulse and flush marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_araddr  <= '0;
            r_inst    <= '0;
            r_bus_err <= 1'b0;
            r_flushed <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_inst <= '0;
                    end else if (ce_i && w_aligned) begin
                        r_araddr  <= pc_i;
                        r_arvalid <= 1'b1;
                    end else if (ce_i) begin
                        // Misaligned PC: report without touching the bus.
                        r_inst    <= '0;
                        r_bus_err <= 1'b1;
                    end
                end
                S_ADDR: begin
                    // ARVALID stays up until accepted even when flushed.
                    if (flush) begin
                        r_flushed <= 1'b1;
                        r_inst    <= '0;
                    end
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_r_hs) begin
                        r_rready  <= 1'b0;
                        r_flushed <= 1'b0;
                        if (w_drop) begin
                            r_inst <= '0;
                        end else if (m_rresp != 2'b00) begin
                            r_inst    <= '0;
                            r_bus_err <= 1'b1;
                        end else begin
                            r_inst <= m_rdata;
                        end
                    end else if (flush) begin
                        r_flushed <= 1'b1;
                        r_inst    <= '0;
                    end
                end
                S_DONE: begin
                    // The word is consumed (or flushed) on leaving DONE.
                    if (flush || !stall_i) begin
                        r_inst <= '0;
                    end
                end
                default: begin
                    r_inst <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_axi.sv
module tb_inst_fetch_axi;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        stall_i;
    logic        flush;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    int checks   = 0;
    int failures = 0;

    inst_fetch_axi #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall_i(stall_i),
        .flush(flush), .inst_o(inst_o), .stallreq_o(stallreq_o),
        .bus_err_o(bus_err_o), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction view) ----------------
    // wait_ar: request issued, address not yet accepted
    // wait_r : address accepted, data not yet returned
    // dead   : the outstanding fetch was flushed
    // holding: a delivered instruction (or error) is on inst_o
    bit          mdl_live = 1'b0;
    bit          wait_ar, wait_r, dead, holding;
    logic [31:0] e_inst, e_addr;
    logic        e_err;
    logic [31:0] ar_seen[$];

    always @(posedge clk) begin
        if (!rst && m_arvalid && m_arready) ar_seen.push_back(m_araddr);
        if (rst) begin
            mdl_live = 1'b1;
            wait_ar = 1'b0; wait_r = 1'b0; dead = 1'b0; holding = 1'b0;
            e_inst = 32'h0; e_addr = 32'h0; e_err = 1'b0;
        end else if (mdl_live) begin
            e_err = 1'b0;
            if (wait_ar) begin
                if (flush) dead = 1'b1;
                if (m_arready) begin
                    wait_ar = 1'b0;
                    wait_r  = 1'b1;
                end
            end else if (wait_r) begin
                if (m_rvalid) begin
                    wait_r = 1'b0;
                    if (dead || flush) begin
                        dead = 1'b0;
                        e_inst = 32'h0;
                    end else if (m_rresp != 2'b00) begin
                        e_inst = 32'h0; e_err = 1'b1; holding = 1'b1;
                    end else begin
                        e_inst = m_rdata; holding = 1'b1;
                    end
                end else if (flush) begin
                    dead = 1'b1;
                end
            end else if (holding) begin
                if (flush || !stall_i) begin
                    holding = 1'b0;
                    e_inst = 32'h0;
                end
            end else begin
                if (flush) begin
                    e_inst = 32'h0;
                end else if (ce_i && pc_i[1:0] == 2'b00) begin
                    wait_ar = 1'b1;
                    e_addr = pc_i;
                end else if (ce_i) begin
                    e_inst = 32'h0; e_err = 1'b1; holding = 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle after the first reset.
    always @(negedge clk) begin
        if (mdl_live) begin
            chk("cmp_inst_o", inst_o, e_inst);
            chk("cmp_bus_err_o", {31'd0, bus_err_o}, {31'd0, e_err});
            chk("cmp_arvalid", {31'd0, m_arvalid}, {31'd0, wait_ar});
            chk("cmp_rready", {31'd0, m_rready}, {31'd0, wait_r});
            chk("cmp_araddr", m_araddr, e_addr);
            chk("cmp_arprot", {29'd0, m_arprot}, 32'd4);
            chk("cmp_stallreq", {31'd0, stallreq_o},
                {31'd0, (wait_ar | wait_r | (!holding & !wait_ar & !wait_r & ce_i & !flush))});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic c, input logic [31:0] p, input logic st, input logic fl,
                       input logic ar, input logic rv, input logic [31:0] rd, input logic [1:0] rr);
        ce_i = c; pc_i = p; stall_i = st; flush = fl;
        m_arready = ar; m_rvalid = rv; m_rdata = rd; m_rresp = rr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          n_stall;
    logic [31:0] exp_ar[11];

    initial begin
        rst = 1'b1;
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
        tick(); tick();
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("rst_rready", {31'd0, m_rready}, 32'd0);
        chk("rst_araddr", m_araddr, 32'h0);
        chk("rst_arprot", {29'd0, m_arprot}, 32'd4);
        rst = 1'b0;

        // T1: zero-wait fetch from 0x0
        drv(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t1_c0_stallreq", {31'd0, stallreq_o}, 32'd1); tick();
        drv(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t1_c1_arvalid", {31'd0, m_arvalid}, 32'd1);
        chk("t1_c1_araddr", m_araddr, 32'h0); tick();
        drv(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3C010001, 2'b00);
        chk("t1_c2_rready", {31'd0, m_rready}, 32'd1);
        chk("t1_c2_stallreq", {31'd0, stallreq_o}, 32'd1); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t1_c3_inst", inst_o, 32'h3C010001);
        chk("t1_c3_stallreq", {31'd0, stallreq_o}, 32'd0); tick();

        // T2: AR waits 3 cycles, R waits 2 cycles
        n_stall = 0;
        for (int i = 0; i <= 8; i++) begin
            drv((i < 8) ? 1'b1 : 1'b0, 32'h40, 1'b0, 1'b0, (i == 4) ? 1'b1 : 1'b0,
                (i == 7) ? 1'b1 : 1'b0, 32'h12345678, 2'b00);
            if (stallreq_o) n_stall++;
            if (i >= 1 && i <= 4) begin
                chk("t2_araddr_stable", m_araddr, 32'h40);
                chk("t2_arvalid_stable", {31'd0, m_arvalid}, 32'd1);
            end
            if (i == 8) chk("t2_inst", inst_o, 32'h12345678);
            tick();
        end
        chk("t2_stall_cycles", n_stall, 32'd8);

        // T3: flush in ADDR for 0x100, then fetch 0x200
        drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00); tick();
        drv(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00); tick();
        drv(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t3_arvalid_held", {31'd0, m_arvalid}, 32'd1);
        chk("t3_araddr_held", m_araddr, 32'h100); tick();
        drv(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 2'b00); tick();
        drv(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t3_dropped_inst", inst_o, 32'h0);
        chk("t3_idle_stallreq", {31'd0, stallreq_o}, 32'd1); tick();
        drv(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t3_next_araddr", m_araddr, 32'h200); tick();
        drv(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA0001, 2'b00); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t3_inst", inst_o, 32'hAAAA0001); tick();

        // T4: stall_i held 4 cycles in DONE
        drv(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00); tick();
        tick();
        drv(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0BADF00D, 2'b00); tick();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h304, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
            chk("t4_inst_held", inst_o, 32'h0BADF00D);
            chk("t4_no_ar", {31'd0, m_arvalid}, 32'd0);
            tick();
        end
        drv(1'b1, 32'h304, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t4_inst_release", inst_o, 32'h0BADF00D); tick();
        drv(1'b1, 32'h304, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t4_idle_arvalid", {31'd0, m_arvalid}, 32'd0); tick();
        drv(1'b1, 32'h304, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t4_next_araddr", m_araddr, 32'h304); tick();
        drv(1'b1, 32'h304, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11112222, 2'b00); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t4_inst", inst_o, 32'h11112222); tick();

        // T5: RRESP error, then misaligned PC
        drv(1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00); tick();
        tick();
        drv(1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 2'b10); tick();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t5_rresp_inst", inst_o, 32'h0);
        chk("t5_rresp_err", {31'd0, bus_err_o}, 32'd1); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t5_err_one_cycle", {31'd0, bus_err_o}, 32'd0); tick();
        drv(1'b1, 32'h102, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t5_misalign_err", {31'd0, bus_err_o}, 32'd1);
        chk("t5_misalign_no_ar", {31'd0, m_arvalid}, 32'd0); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t5_misalign_pulse_end", {31'd0, bus_err_o}, 32'd0); tick();

        // T6: reset while in DATA, then recover
        drv(1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00); tick();
        tick();
        rst = 1'b1;
        drv(1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t6_in_data", {31'd0, m_rready}, 32'd1); tick();
        rst = 1'b0;
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t6_rst_rready", {31'd0, m_rready}, 32'd0);
        chk("t6_rst_araddr", m_araddr, 32'h0);
        chk("t6_rst_stallreq", {31'd0, stallreq_o}, 32'd0); tick();
        drv(1'b1, 32'h600, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00); tick();
        tick();
        drv(1'b1, 32'h600, 1'b0, 1'b0, 1'b1, 1'b1, 32'h600DCAFE, 2'b00); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t6_recover_inst", inst_o, 32'h600DCAFE); tick();

        // T7: flush on the R handshake cycle, then flush in DONE
        drv(1'b1, 32'h700, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00); tick();
        tick();
        drv(1'b1, 32'h700, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55555555, 2'b00); tick();
        drv(1'b1, 32'h704, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t7_flush_r_inst", inst_o, 32'h0);
        chk("t7_flush_r_idle", {31'd0, stallreq_o}, 32'd1); tick();
        tick();
        drv(1'b1, 32'h704, 1'b0, 1'b0, 1'b1, 1'b1, 32'h77777777, 2'b00); tick();
        drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t7_done_inst", inst_o, 32'h77777777); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("t7_done_flushed", inst_o, 32'h0); tick();

        // Every AR handshake in order
        exp_ar = '{32'h0, 32'h40, 32'h100, 32'h200, 32'h300, 32'h304,
                   32'h400, 32'h500, 32'h600, 32'h700, 32'h704};
        chk("ar_count", ar_seen.size(), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < ar_seen.size()) chk("ar_addr_seq", ar_seen[i], exp_ar[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
